// File: rtl/twiddle_stream_gen.sv
// Streams the twiddles W^k (or conjugates) of one FFT stage from a folded quarter-wave sine ROM.
// First twiddle one cycle after request acceptance, then one per cycle; resp_* hold while resp_rdy is low.
module twiddle_stream_gen #(
    parameter  int BIT_WIDTH     = 32,
    parameter  int DECIMAL_POINT = 16,
    parameter  int SIZE_FFT      = 64,
    localparam int LOG2N         = $clog2(SIZE_FFT),
    localparam int SW            = $clog2(LOG2N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [SW-1:0]        req_stage,
    input  logic                 req_inv,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [BIT_WIDTH-1:0] resp_re,
    output logic [BIT_WIDTH-1:0] resp_im,
    output logic [LOG2N-2:0]     resp_idx,
    output logic                 resp_last
);

    localparam int              QN    = SIZE_FFT / 4;
    localparam int              KW    = LOG2N - 1;
    localparam logic [SW-1:0]   SMAX  = SW'(LOG2N - 1);
    localparam logic [KW-1:0]   QN_K  = KW'(QN);
    localparam longint          PI_FX = 64'sd3373259426;   // pi scaled by 2^30

    // sin(2*pi*o/N) by Taylor series in 2^-30 fixed point, rounded to DECIMAL_POINT bits
    function automatic longint sin_fx(input int o);
        longint x, term, sum;
        x    = (PI_FX * 2 * longint'(o)) / longint'(SIZE_FFT);
        term = x;
        sum  = x;
        for (int i = 1; i <= 10; i++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        return ((sum <<< DECIMAL_POINT) + (64'sd1 <<< 29)) >>> 30;
    endfunction

    logic [BIT_WIDTH-1:0] rom [QN+1];

    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam longint QV = sin_fx(g);
        assign rom[g] = BIT_WIDTH'(QV);
    end

    function automatic logic [BIT_WIDTH-1:0] fold(input logic [LOG2N-1:0] p);
        logic [KW-1:0]        oi;
        logic [BIT_WIDTH-1:0] mag;
        oi = {1'b0, p[LOG2N-3:0]};
        if (p[LOG2N-2]) oi = QN_K - oi;
        mag = rom[oi];
        return p[LOG2N-1] ? -mag : mag;
    endfunction

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic                 inv_q, inv_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 val_q, val_d;
    logic                 last_q, last_d;
    logic [BIT_WIDTH-1:0] re_q, re_d;
    logic [BIT_WIDTH-1:0] im_q, im_d;
    logic                 load;
    logic [SW-1:0]        stage_clamped;
    logic [LOG2N-1:0]     phase_d;
    logic [LOG2N-1:0]     kmax_d;
    logic [BIT_WIDTH-1:0] sin_d;

    assign stage_clamped = ({1'b0, req_stage} > {1'b0, SMAX}) ? SMAX : req_stage;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        k_d     = k_q;
        val_d   = val_q;
        last_d  = last_q;
        re_d    = re_q;
        im_d    = im_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    stage_d = stage_clamped;
                    inv_d   = req_inv;
                    k_d     = '0;
                    val_d   = 1'b1;
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (resp_rdy) begin
                    if (last_q) begin
                        val_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d  = k_q + KW'(1);
                        load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // phase index k * N/2^(s+1) is k shifted into the top of the phase word
        phase_d = {1'b0, k_d} << (SMAX - stage_d);
        kmax_d  = (LOG2N'(1) << stage_d) - LOG2N'(1);
        sin_d   = fold(phase_d);
        if (load) begin
            last_d = ({1'b0, k_d} == kmax_d);
            re_d   = fold(phase_d + LOG2N'(QN));
            im_d   = inv_d ? sin_d : -sin_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            inv_q   <= 1'b0;
            k_q     <= '0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            k_q     <= k_d;
            val_q   <= val_d;
            last_q  <= last_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign req_rdy   = (state_q == ST_IDLE);
    assign resp_val  = val_q;
    assign resp_re   = re_q;
    assign resp_im   = im_q;
    assign resp_idx  = k_q;
    assign resp_last = last_q;

endmodule
